// File: rtl/board_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | board_scanner_if : start/clear control, RAM read port and results   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface board_scanner_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              clear;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic              busy;
  logic              done;
  logic [1:0]        winner;
  logic              draw;
  logic              gameover;
  logic              cell_err;
  logic [7:0]        win_line;

  modport master (
    input  start, clear, rd_data,
    output rd_en, rd_addr, busy, done, winner, draw, gameover, cell_err, win_line
  );

  modport slave (
    output start, clear, rd_data,
    input  rd_en, rd_addr, busy, done, winner, draw, gameover, cell_err, win_line
  );
endinterface
`default_nettype wire

// File: rtl/board_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | board_scanner : reads the 9-cell board from RAM, evaluates 8 lines  |
// | Option macro BOARD_SCANNER_WIN_LINE_EN builds the win_line register |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module board_scanner #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 4
) (
  input logic             clk,
  input logic             reset,
  board_scanner_if.master bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(8);
  localparam int LINE_CELL [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              rd_en, busy, done;
  logic              pipe_vld  [READ_LAT];
  logic [ADDR_W-1:0] pipe_addr [READ_LAT];
  logic [1:0]        shadow    [9];
  logic              last_captured;
  logic [7:0]        x_line, o_line;
  logic              board_full, any_corrupt;
  logic [1:0]        new_winner;
  logic              new_draw, new_over;
  logic [1:0]        winner;
  logic              draw, gameover, cell_err;

  assign last_captured = pipe_vld[READ_LAT-1] && (pipe_addr[READ_LAT-1] == LAST_CELL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = READ;
      READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (addr == LAST_CELL) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_captured) state_nxt = EVAL;
      end
      EVAL: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                addr <= '0;
    else if (state == READ && addr != LAST_CELL) addr <= addr + 1'b1;
    else                                      addr <= '0;
  end

  // Delay line tagging each issued address so its data lands READ_LAT cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_en;
      pipe_addr[0] <= addr;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 9; n++) shadow[n] <= 2'b00;
    end else if (pipe_vld[READ_LAT-1]) begin
      for (int n = 0; n < 9; n++) begin
        if (pipe_addr[READ_LAT-1] == ADDR_W'(n)) shadow[n] <= bus.rd_data;
      end
    end
  end

  // Corrupt cells (11) never match a player code, so they behave as empty.
  always_comb begin
    x_line      = '0;
    o_line      = '0;
    board_full  = 1'b1;
    any_corrupt = 1'b0;
    for (int l = 0; l < 8; l++) begin
      x_line[l] = (shadow[LINE_CELL[l][0]] == 2'b01) && (shadow[LINE_CELL[l][1]] == 2'b01) &&
                  (shadow[LINE_CELL[l][2]] == 2'b01);
      o_line[l] = (shadow[LINE_CELL[l][0]] == 2'b10) && (shadow[LINE_CELL[l][1]] == 2'b10) &&
                  (shadow[LINE_CELL[l][2]] == 2'b10);
    end
    for (int n = 0; n < 9; n++) begin
      if (shadow[n] == 2'b11) any_corrupt = 1'b1;
      if (shadow[n] == 2'b00 || shadow[n] == 2'b11) board_full = 1'b0;
    end
  end

  assign new_winner = {|o_line, |x_line};
  assign new_draw   = board_full && (new_winner == 2'b00);
  assign new_over   = (new_winner != 2'b00) || new_draw;

  // Results load on the EVAL->DONE edge and override a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner   <= 2'b00;
      draw     <= 1'b0;
      gameover <= 1'b0;
      cell_err <= 1'b0;
    end else if (state == EVAL) begin
      winner   <= new_winner;
      draw     <= new_draw;
      gameover <= new_over | (gameover & ~bus.clear);
      cell_err <= any_corrupt | (cell_err & ~bus.clear);
    end else if (bus.clear && state != DONE) begin
      winner   <= 2'b00;
      draw     <= 1'b0;
      gameover <= 1'b0;
      cell_err <= 1'b0;
    end
  end

`ifdef BOARD_SCANNER_WIN_LINE_EN
  logic [7:0] win_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               win_line <= 8'h00;
    else if (state == EVAL)                  win_line <= x_line | o_line;
    else if (bus.clear && state != DONE)     win_line <= 8'h00;
  end

  assign bus.win_line = win_line;
`else
  assign bus.win_line = 8'h00;
`endif

  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = addr;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.winner   = winner;
  assign bus.draw     = draw;
  assign bus.gameover = gameover;
  assign bus.cell_err = cell_err;
endmodule
`default_nettype wire

// File: tb/tb_board_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_board_scanner : directed vectors on READ_LAT=1 and READ_LAT=3    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_board_scanner;
  logic clk = 1'b0;
  logic reset, start, clear;
  logic [1:0] mem [9];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      board;
    logic [1:0] w;
    logic       d;
    logic       g;
    logic       e;
    logic [7:0] wl;
  } vec_t;

  vec_t tbl [10];

  board_scanner_if #(.ADDR_W(4)) bus1 ();
  board_scanner_if #(.ADDR_W(4)) bus3 ();

  assign bus1.start = start;
  assign bus1.clear = clear;
  assign bus3.start = start;
  assign bus3.clear = clear;

  board_scanner #(.READ_LAT(1), .ADDR_W(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));
  board_scanner #(.READ_LAT(3), .ADDR_W(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3.master));

  always #5 clk = ~clk;

  function automatic logic [1:0] ram_rd(input logic [3:0] a);
    return (a < 4'd9) ? mem[a] : 2'b00;
  endfunction

  logic [1:0] q1, q3a, q3b, q3c;
  always @(posedge clk) begin
    q1  <= ram_rd(bus1.rd_addr);
    q3a <= ram_rd(bus3.rd_addr);
    q3b <= q3a;
    q3c <= q3b;
  end
  assign bus1.rd_data = q1;
  assign bus3.rd_data = q3c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input string b);
    for (int i = 0; i < 9; i++) begin
      case (b[i])
        "X":     mem[i] = 2'b01;
        "O":     mem[i] = 2'b10;
        "#":     mem[i] = 2'b11;
        default: mem[i] = 2'b00;
      endcase
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic chk_res(input string nm, input logic [1:0] w, input logic d, input logic g,
                         input logic e, input logic [7:0] wl);
    logic [7:0] wl_e;
`ifdef BOARD_SCANNER_WIN_LINE_EN
    wl_e = wl;
`else
    wl_e = 8'h00;
`endif
    chk({nm, "/L1 winner"},   bus1.winner,   w);
    chk({nm, "/L1 draw"},     bus1.draw,     d);
    chk({nm, "/L1 gameover"}, bus1.gameover, g);
    chk({nm, "/L1 cell_err"}, bus1.cell_err, e);
    chk({nm, "/L1 win_line"}, bus1.win_line, wl_e);
    chk({nm, "/L3 winner"},   bus3.winner,   w);
    chk({nm, "/L3 draw"},     bus3.draw,     d);
    chk({nm, "/L3 gameover"}, bus3.gameover, g);
    chk({nm, "/L3 cell_err"}, bus3.cell_err, e);
    chk({nm, "/L3 win_line"}, bus3.win_line, wl_e);
  endtask

  // Cycle k is the k-th cycle after the edge that sampled start; a done seen
  // in cycle k is captured by that edge k.  xk: extra start cycle, ck: clear
  // held for cycles ck and ck+1 (0 disables either).
  task automatic do_scan(input string nm, input string b, input int xk, input int ck);
    int d1, d3, nd1, nd3, r1, r3;
    bit ok1, ok3;
    d1 = 0; d3 = 0; nd1 = 0; nd3 = 0; r1 = 0; r3 = 0; ok1 = 1'b1; ok3 = 1'b1;
    load(b);
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == xk);
      clear = (ck != 0) && (k == ck || k == ck + 1);
      if (bus1.rd_en) begin
        if (bus1.rd_addr != 4'(r1) || k != r1 + 1) ok1 = 1'b0;
        r1++;
      end
      if (bus3.rd_en) begin
        if (bus3.rd_addr != 4'(r3) || k != r3 + 1) ok3 = 1'b0;
        r3++;
      end
      if (bus1.done) begin nd1++; if (d1 == 0) d1 = k; end
      if (bus3.done) begin nd3++; if (d3 == 0) d3 = k; end
    end
    start = 1'b0;
    clear = 1'b0;
    chk({nm, "/L1 done_cycle"}, d1, 12);
    chk({nm, "/L3 done_cycle"}, d3, 14);
    chk({nm, "/L1 done_count"}, nd1, 1);
    chk({nm, "/L3 done_count"}, nd3, 1);
    chk({nm, "/L1 reads"}, r1, 9);
    chk({nm, "/L3 reads"}, r3, 9);
    chk({nm, "/L1 addr_order"}, ok1, 1);
    chk({nm, "/L3 addr_order"}, ok3, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, waited;
    tbl[0] = '{"XXXOO....", 2'b01, 1'b0, 1'b1, 1'b0, 8'h01};
    tbl[1] = '{"XOXXOOOXX", 2'b00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{".........", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{"......OOO", 2'b10, 1'b0, 1'b1, 1'b0, 8'h04};
    tbl[4] = '{"XXXOOO...", 2'b11, 1'b0, 1'b1, 1'b0, 8'h03};
    tbl[5] = '{"XXXX..X..", 2'b01, 1'b0, 1'b1, 1'b0, 8'h09};
    tbl[6] = '{"X#..X...X", 2'b01, 1'b0, 1'b1, 1'b1, 8'h40};
    tbl[7] = '{"XOXOXOOXX", 2'b01, 1'b0, 1'b1, 1'b0, 8'h40};
    tbl[8] = '{"XOX#OOOXX", 2'b00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[9] = '{".X..X..X.", 2'b01, 1'b0, 1'b1, 1'b0, 8'h10};

    reset = 1'b1; start = 1'b0; clear = 1'b0;
    load(".........");
    repeat (3) @(negedge clk);
    chk("reset/L1 busy",  bus1.busy,  0);
    chk("reset/L1 rd_en", bus1.rd_en, 0);
    chk("reset/L3 done",  bus3.done,  0);
    chk_res("reset", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      pulse_clear();
      do_scan(tbl[i].board, tbl[i].board, 0, 0);
      chk_res(tbl[i].board, tbl[i].w, tbl[i].d, tbl[i].g, tbl[i].e, tbl[i].wl);
    end

    // Second start while busy must be ignored; then clear wipes results.
    pulse_clear();
    do_scan("anti_extra_start", "X.OXO.O..", 5, 0);
    chk_res("anti_extra_start", 2'b10, 1'b0, 1'b1, 1'b0, 8'h80);
    pulse_clear();
    chk_res("after_clear", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);

    // cell_err stays set across a clean scan until clear.
    do_scan("corrupt5", ".....#...", 0, 0);
    chk_res("corrupt5", 2'b00, 1'b0, 1'b0, 1'b1, 8'h00);
    do_scan("clean_after_err", ".........", 0, 0);
    chk_res("clean_after_err", 2'b00, 1'b0, 1'b0, 1'b1, 8'h00);
    pulse_clear();
    chk_res("err_cleared", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);

    // gameover sticky over a later non-winning scan.
    do_scan("win_row0", "XXXOO....", 0, 0);
    do_scan("empty_after_win", ".........", 0, 0);
    chk_res("empty_after_win", 2'b00, 1'b0, 1'b1, 1'b0, 8'h00);

    // Clear coinciding with result load: new results win, old sticky err dropped.
    do_scan("corrupt4", "....#....", 0, 0);
    do_scan("clear_at_done", "XXXOO....", 0, 11);
    chk_res("clear_at_done", 2'b01, 1'b0, 1'b1, 1'b0, 8'h01);

    // Reset asserted mid-READ at rd_addr 4.
    load("XXXOO....");
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    waited = 0;
    while (bus1.rd_addr != 4'd4 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("midreset/reach_addr4", bus1.rd_addr, 4);
    reset = 1'b1;
    #1;
    chk("midreset/L1 busy",    bus1.busy,    0);
    chk("midreset/L1 rd_en",   bus1.rd_en,   0);
    chk("midreset/L1 rd_addr", bus1.rd_addr, 0);
    chk("midreset/L3 busy",    bus3.busy,    0);
    chk("midreset/L3 rd_en",   bus3.rd_en,   0);
    chk_res("midreset", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk) reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus1.done || bus3.done) nd++;
    end
    chk("midreset/no_done", nd, 0);

    do_scan("recover_draw", "XOXXOOOXX", 0, 0);
    chk_res("recover_draw", 2'b00, 1'b1, 1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/board_scanner.md
Name: board_scanner

Overview:
- Reads the tic-tac-toe board back out of the board RAM after each move is written, one cell per cycle.
- Evaluates all 8 winning lines and reports winner, draw or gameover to the display and input logic.
- Sits on the RAM read port. It is the reader counterpart to the move-writing path (validate/set move into RAM).

Parameters:
- READ_LAT, 1, RAM read latency in cycles from rd_en/rd_addr to valid rd_data (legal 1..3).
- ADDR_W, 4, width of the RAM cell address.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse requesting a board scan (issued after a move write).
- clear  input  1  synchronous new-game clear of sticky result outputs.
- rd_en  output  1  RAM read enable.
- rd_addr  output  ADDR_W  RAM cell address, 0..8.
- rd_data  input  2  cell code: 00 empty, 01 X, 10 O, 11 corrupt.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results are valid.
- winner  output  2  00 none, 01 X, 10 O, 11 both (illegal board).
- draw  output  1  board full and no winner.
- gameover  output  1  sticky; set when winner!=00 or draw.
- cell_err  output  1  sticky; any cell read as 11 during the last scan.
- win_line  output  8  one-hot winning line (see Optional Feature).

Behaviour:
- Reset (async): state IDLE; all outputs 0; rd_addr 0; shadow board cleared.
- FSM states: IDLE, READ, DRAIN, EVAL, DONE.
- IDLE: start=1 moves to READ at the next edge. start is ignored in every other state (no queueing).
- READ: rd_en=1 for exactly 9 consecutive cycles; rd_addr = 0,1,...,8. Counter wraps to IDLE-safe 0 after 8. Then goes to DRAIN.
- Capture: rd_data is stored into shadow cell n exactly READ_LAT cycles after address n was issued.
- DRAIN: rd_en=0 for READ_LAT cycles until the last cell is captured, then goes to EVAL.
- EVAL (1 cycle): compute the results from the shadow board.
  - Line order: 0 row(0,1,2), 1 row(3,4,5), 2 row(6,7,8), 3 col(0,3,6), 4 col(1,4,7), 5 col(2,5,8), 6 diag(0,4,8), 7 anti(2,4,6).
  - A line wins for a player when all 3 of its cells carry that player's code.
  - Code 11 counts as empty for line and full checks and sets cell_err.
- DONE (1 cycle): done=1, then IDLE.
  - winner, draw and win_line update on entry to DONE and hold until the next DONE or clear.
  - Latency: done is high exactly 11+READ_LAT edges after the edge that sampled start (12 at default).
- busy=1 in READ, DRAIN, EVAL and DONE.
- Result rules:
  - Both X and O have a winning line: winner=11, gameover=1.
  - draw=1 only when all 9 cells are non-empty and winner=00.
- gameover and cell_err are sticky. They are cleared only by reset or by clear.
- clear: zeroes winner, draw, gameover, cell_err and win_line. It does not abort a scan in progress.
  - If clear and DONE coincide, DONE's results win.
- Reset mid-scan: returns to IDLE immediately; partial shadow data is discarded; no done pulse.

Optional Feature:
- Macro: BOARD_SCANNER_WIN_LINE_EN.
- Defined: win_line[i]=1 for every line i that won in the last EVAL. Normally this is one-hot; a multi-line win such as a fork-fill sets several bits.
- Undefined: win_line is tied to 8'h00 and no line-tracking registers are built. Other behaviour is identical.

Test Plan:
- Reset mid-READ (assert reset when rd_addr=4) -> busy=0, rd_en=0, all outputs 0 the same cycle; no done afterwards.
- Board X at 0,1,2, O at 3,4, rest empty; start -> rd_addr 0..8 on 9 cycles; done at start edge+12; winner=01, draw=0, gameover=1, win_line=8'h01 (macro on) / 8'h00 (off).
- Full board X O X / X O O / O X X; start -> winner=00, draw=1, gameover=1, win_line=0.
- O at 2,4,6 and X at 0,3; second start pulsed while busy -> exactly one done; winner=10, win_line=8'h80. Then clear -> all results 0.
- Cell 5 reads 11, rest empty -> winner=00, draw=0, cell_err=1 and it stays 1 after a later clean scan until clear.
- READ_LAT=3, X on column (1,4,7) -> done at start edge+14; winner=01, win_line=8'h10.
